// File: rtl/arbitro_rr4a1_if.sv
// Bus between the four per-class input FIFOs, the merging arbiter and the downstream FIFO.
// The arbiter uses the master modport; the FIFO side (or a bench) uses the slave modport.
interface arbitro_rr4a1_if #(
    parameter int unsigned WORD_SIZE = 12
);
    logic [WORD_SIZE-1:0] data_in_arb0;
    logic [WORD_SIZE-1:0] data_in_arb1;
    logic [WORD_SIZE-1:0] data_in_arb2;
    logic [WORD_SIZE-1:0] data_in_arb3;
    logic [3:0]           fifos_empty;
    logic                 fifo_almost_full;
    logic [3:0]           pop;
    logic                 push;
    logic [WORD_SIZE-1:0] data_out_arb;
    logic [1:0]           state;

    modport master (
        input  data_in_arb0, data_in_arb1, data_in_arb2, data_in_arb3,
        input  fifos_empty, fifo_almost_full,
        output pop, push, data_out_arb, state
    );

    modport slave (
        output data_in_arb0, data_in_arb1, data_in_arb2, data_in_arb3,
        output fifos_empty, fifo_almost_full,
        input  pop, push, data_out_arb, state
    );
endinterface

// File: rtl/arbitro_rr4a1.sv
// Round-robin merge of four first-word-fall-through FIFOs into one downstream FIFO.
// pop is combinational; push/data_out_arb follow one cycle later.
module arbitro_rr4a1 #(
    parameter int unsigned WORD_SIZE = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    arbitro_rr4a1_if.master      bus
);
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           rr_ptr;
    logic                 push_q;
    logic [WORD_SIZE-1:0] data_q;

    logic [WORD_SIZE-1:0] heads [4];
    logic [3:0]           nonempty;
    logic [3:0]           raw_elig;
    logic [3:0]           eligible;
    logic [1:0]           cand;
    logic [1:0]           grant_idx;
    logic                 grant_any;
    logic [3:0]           grant_oh;

    assign heads[0] = bus.data_in_arb0;
    assign heads[1] = bus.data_in_arb1;
    assign heads[2] = bus.data_in_arb2;
    assign heads[3] = bus.data_in_arb3;

    assign nonempty = ~bus.fifos_empty;
    assign raw_elig = nonempty & {4{~bus.fifo_almost_full}};
    // Nothing may be popped during the single post-reset cycle.
    assign eligible = (state_q == ST_RESET) ? 4'b0000 : raw_elig;

    // First eligible index scanning rr_ptr, rr_ptr+1, ... modulo 4.
    always_comb begin
        grant_idx = rr_ptr;
        grant_any = 1'b0;
        cand      = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!grant_any && eligible[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
        grant_oh = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    end

    // Outside RESET, a grant exists exactly when raw_elig is non-zero, so one rule covers all states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            rr_ptr  <= 2'd0;
            push_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            if (|raw_elig) begin
                state_q <= ST_ACTIVE;
            end else if (bus.fifo_almost_full && (|nonempty)) begin
                state_q <= ST_STALL;
            end else begin
                state_q <= ST_IDLE;
            end

            if (grant_any) begin
                data_q <= heads[grant_idx];
                push_q <= 1'b1;
                rr_ptr <= grant_idx + 2'd1;
            end else begin
                push_q <= 1'b0;
            end
        end
    end

    assign bus.pop          = grant_oh;
    assign bus.push         = push_q;
    assign bus.data_out_arb = data_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_arbitro_rr4a1.sv
// Scoreboard bench for arbitro_rr4a1: bench-side FIFO queues feed the arbiter, popped words
// are queued as expected output and matched against push/data_out_arb one cycle later.
module tb_arbitro_rr4a1;
    localparam int unsigned WORD_SIZE = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbitro_rr4a1_if #(.WORD_SIZE(WORD_SIZE)) bus ();
    arbitro_rr4a1 #(.WORD_SIZE(WORD_SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [11:0] fq [4][$];
    logic [11:0] sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_rr     = 0;
    logic [1:0]  m_state  = 2'd0;
    logic        m_push   = 1'b0;
    logic [11:0] m_last   = 12'h000;

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) bus.fifos_empty[i] = (fq[i].size() == 0);
        bus.data_in_arb0 = (fq[0].size() != 0) ? fq[0][0] : 12'h000;
        bus.data_in_arb1 = (fq[1].size() != 0) ? fq[1][0] : 12'h000;
        bus.data_in_arb2 = (fq[2].size() != 0) ? fq[2][0] : 12'h000;
        bus.data_in_arb3 = (fq[3].size() != 0) ? fq[3][0] : 12'h000;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) fq[i].delete();
    endtask

    // One clock: drive, predict pop, queue the popped word, then check registered outputs.
    task automatic run_cycle(input logic af, input string tag, output logic [3:0] seen);
        logic [3:0]  exp_pop;
        logic [11:0] exp_w;
        int          g;
        int          idx;
        bit          any_ne;
        bus.fifo_almost_full = af;
        drive_inputs();
        #1;
        exp_pop = 4'b0000;
        g       = -1;
        any_ne  = 1'b0;
        for (int i = 0; i < 4; i++) if (fq[i].size() != 0) any_ne = 1'b1;
        if (m_state != 2'd0 && !af) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_rr + k) % 4;
                if (g < 0 && fq[idx].size() != 0) g = idx;
            end
        end
        if (g >= 0) exp_pop[g] = 1'b1;
        seen = bus.pop;
        n_checks++;
        if (bus.pop !== exp_pop) begin
            n_fail++;
            $display("FAIL %s pop: got %b expected %b", tag, bus.pop, exp_pop);
        end
        if (g >= 0) begin
            sb.push_back(fq[g][0]);
            void'(fq[g].pop_front());
            m_rr   = (g + 1) % 4;
            m_push = 1'b1;
        end else begin
            m_push = 1'b0;
        end
        if (!af && any_ne)      m_state = 2'd2;
        else if (af && any_ne)  m_state = 2'd3;
        else                    m_state = 2'd1;

        @(posedge clk);
        #1;
        n_checks++;
        if (bus.push !== m_push) begin
            n_fail++;
            $display("FAIL %s push: got %b expected %b", tag, bus.push, m_push);
        end
        if (bus.push === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s sb_underflow: got push=1 expected no word in flight", tag);
            end else begin
                exp_w  = sb.pop_front();
                m_last = exp_w;
                if (bus.data_out_arb !== exp_w) begin
                    n_fail++;
                    $display("FAIL %s data: got %h expected %h", tag, bus.data_out_arb, exp_w);
                end
            end
        end else begin
            n_checks++;
            if (bus.data_out_arb !== m_last) begin
                n_fail++;
                $display("FAIL %s data_hold: got %h expected %h", tag, bus.data_out_arb, m_last);
            end
        end
        n_checks++;
        if (bus.state !== m_state) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", tag, bus.state, m_state);
        end
    endtask

    task automatic drain(input string tag);
        logic [3:0] seen;
        for (int n = 0; n < 24; n++) begin
            if (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() == 0) break;
            run_cycle(1'b0, tag, seen);
        end
        run_cycle(1'b0, tag, seen);
        n_checks++;
        if (sb.size() != 0 || bus.state !== 2'd1) begin
            n_fail++;
            $display("FAIL %s drained: got sb=%0d state=%0d expected sb=0 state=1", tag, sb.size(), bus.state);
        end
    endtask

    task automatic test_reset();
        logic [3:0] seen;
        reset = 1'b1;
        bus.fifo_almost_full = 1'b0;
        clear_fifos();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) fq[i].push_back(12'(12'h100 + 12'h101 * i));
        drive_inputs();
        #2 reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.pop !== 4'b0000 || bus.push !== 1'b0 || bus.data_out_arb !== 12'h000 || bus.state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got pop=%b push=%b data=%h state=%0d expected 0000 0 000 0",
                         bus.pop, bus.push, bus.data_out_arb, bus.state);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.pop !== 4'b0000 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: got pop=%b state=%0d expected 0000 0", bus.pop, bus.state);
        end
        m_state = 2'd0; m_rr = 0; m_push = 1'b0; m_last = 12'h000;
        run_cycle(1'b0, "reset_first", seen);
    endtask

    task automatic test_round_robin();
        logic [3:0]  seen;
        logic [3:0]  pop_tab [5];
        logic [11:0] dat_tab [5];
        pop_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        dat_tab = '{12'h100, 12'h201, 12'h302, 12'h403, 12'h100};
        for (int k = 0; k < 5; k++) begin
            run_cycle(1'b0, "rr", seen);
            n_checks++;
            if (seen !== pop_tab[k] || bus.data_out_arb !== dat_tab[k] || bus.push !== 1'b1 || bus.state !== 2'd2) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got pop=%b data=%h push=%b state=%0d expected %b %h 1 2",
                         k, seen, bus.data_out_arb, bus.push, bus.state, pop_tab[k], dat_tab[k]);
            end
        end
    endtask

    task automatic test_skip_empty();
        logic [3:0] seen;
        logic [3:0] pop_tab [3];
        pop_tab = '{4'b0100, 4'b0001, 4'b0100};
        fq[1].delete();
        fq[3].delete();
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b0, "skip", seen);
            n_checks++;
            if (seen !== pop_tab[k] || bus.push !== 1'b1) begin
                n_fail++;
                $display("FAIL skip_seq[%0d]: got pop=%b push=%b expected %b 1", k, seen, bus.push, pop_tab[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] seen;
        clear_fifos();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) fq[i].push_back(12'(12'h500 + 16 * i + j));
        run_cycle(1'b0, "bp_pre", seen);
        n_checks++;
        if (seen !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_pre0: got pop=%b expected 1000", seen);
        end
        run_cycle(1'b0, "bp_pre", seen);
        run_cycle(1'b1, "bp_af", seen);
        n_checks++;
        if (seen !== 4'b0000 || bus.push !== 1'b0 || bus.state !== 2'd3) begin
            n_fail++;
            $display("FAIL bp_stall: got pop=%b push=%b state=%0d expected 0000 0 3", seen, bus.push, bus.state);
        end
        run_cycle(1'b1, "bp_af", seen);
        run_cycle(1'b0, "bp_resume", seen);
        n_checks++;
        if (seen !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_resume: got pop=%b expected 0010", seen);
        end
        drain("bp_drain");
    endtask

    task automatic test_drain_idle();
        logic [3:0] seen;
        fq[3].push_back(12'hABC);
        run_cycle(1'b0, "idle_pop", seen);
        n_checks++;
        if (seen !== 4'b1000 || bus.push !== 1'b1 || bus.data_out_arb !== 12'hABC) begin
            n_fail++;
            $display("FAIL idle_pop: got pop=%b push=%b data=%h expected 1000 1 abc", seen, bus.push, bus.data_out_arb);
        end
        run_cycle(1'b0, "idle_after", seen);
        n_checks++;
        if (bus.push !== 1'b0 || bus.data_out_arb !== 12'hABC || bus.state !== 2'd1) begin
            n_fail++;
            $display("FAIL idle_hold: got push=%b data=%h state=%0d expected 0 abc 1", bus.push, bus.data_out_arb, bus.state);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++) fq[i].push_back(12'(12'h700 + 16 * i + j));
        run_cycle(1'b0, "mid_pre", seen);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.push !== 1'b0 || bus.data_out_arb !== 12'h000 || bus.state !== 2'd0 || bus.pop !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got push=%b data=%h state=%0d pop=%b expected 0 000 0 0000",
                     bus.push, bus.data_out_arb, bus.state, bus.pop);
        end
        sb.delete();
        m_state = 2'd0; m_rr = 0; m_push = 1'b0; m_last = 12'h000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_cycle(1'b0, "mid_rst", seen);
        run_cycle(1'b0, "mid_restart", seen);
        n_checks++;
        if (seen !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_restart: got pop=%b expected 0001", seen);
        end
        drain("mid_drain");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip_empty();
        test_backpressure();
        test_drain_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
